// File: rtl/eh2_pkg.sv
// eh2_pkg: shared FSM state type, AXI response codes and size/alignment helper
package eh2_pkg;
    typedef enum logic [2:0] {IDLE, WR_DATA, WR_MEM, WR_RESP, RD_MEM, RD_RESP} axi_sram_state_t;
    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    function automatic logic bad_size(input logic [2:0] size, input logic [2:0] lsb);
        logic [2:0] mask;
        mask = size[1] ? (size[0] ? 3'b111 : 3'b011) : (size[0] ? 3'b001 : 3'b000);
        return size[2] | (|(lsb & mask));
    endfunction
endpackage

// File: rtl/axi4_sram_slave_if.sv
// axi4_sram_slave_if: single-beat AXI4 AW/W/B/AR/R channel bundle
interface axi4_sram_slave_if #(parameter int TAG = 1);
    logic           axi_awvalid;
    logic           axi_awready;
    logic [TAG-1:0] axi_awid;
    logic [31:0]    axi_awaddr;
    logic [2:0]     axi_awsize;
    logic [7:0]     axi_awlen;
    logic [1:0]     axi_awburst;
    logic           axi_wvalid;
    logic           axi_wready;
    logic [63:0]    axi_wdata;
    logic [7:0]     axi_wstrb;
    logic           axi_wlast;
    logic           axi_bvalid;
    logic           axi_bready;
    logic [TAG-1:0] axi_bid;
    logic [1:0]     axi_bresp;
    logic           axi_arvalid;
    logic           axi_arready;
    logic [TAG-1:0] axi_arid;
    logic [31:0]    axi_araddr;
    logic [2:0]     axi_arsize;
    logic [7:0]     axi_arlen;
    logic           axi_rvalid;
    logic           axi_rready;
    logic [TAG-1:0] axi_rid;
    logic [63:0]    axi_rdata;
    logic [1:0]     axi_rresp;
    logic           axi_rlast;
    modport master (
        output axi_awvalid, axi_awid, axi_awaddr, axi_awsize, axi_awlen, axi_awburst,
        output axi_wvalid, axi_wdata, axi_wstrb, axi_wlast, axi_bready,
        output axi_arvalid, axi_arid, axi_araddr, axi_arsize, axi_arlen, axi_rready,
        input  axi_awready, axi_wready, axi_bvalid, axi_bid, axi_bresp,
        input  axi_arready, axi_rvalid, axi_rid, axi_rdata, axi_rresp, axi_rlast
    );
    modport slave (
        input  axi_awvalid, axi_awid, axi_awaddr, axi_awsize, axi_awlen, axi_awburst,
        input  axi_wvalid, axi_wdata, axi_wstrb, axi_wlast, axi_bready,
        input  axi_arvalid, axi_arid, axi_araddr, axi_arsize, axi_arlen, axi_rready,
        output axi_awready, axi_wready, axi_bvalid, axi_bid, axi_bresp,
        output axi_arready, axi_rvalid, axi_rid, axi_rdata, axi_rresp, axi_rlast
    );
endinterface

// File: rtl/rvdffe.sv
// rvdffe: enabled flop with asynchronous active-high reset to zero
module rvdffe #(parameter int WIDTH = 1) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    always_ff @(posedge clk or posedge rst)
        if (rst) dout <= '0;
        else if (en) dout <= din;
endmodule

// File: rtl/rvrangecheck.sv
// rvrangecheck: addr lies in [BASE, BASE + 2^SIZE_LOG2); addresses below BASE wrap high and fail
module rvrangecheck #(
    parameter logic [31:0] BASE = 32'h0,
    parameter int SIZE_LOG2 = 13
) (
    input  logic [31:0] addr,
    output logic        in_range
);
    logic [31:0] off;
    assign off = addr - BASE;
    assign in_range = {1'b0, off} < (33'd1 << SIZE_LOG2);
endmodule

// File: rtl/axi4_sram_slave.sv
// axi4_sram_slave: single-beat AXI4 slave in front of a 64-bit synchronous SRAM.
// Optional sticky first-error address log under AXI4_SRAM_SLAVE_ERRLOG_EN.
module axi4_sram_slave
    import eh2_pkg::*;
#(
    parameter int TAG = 1,
    parameter int DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    axi4_sram_slave_if.slave      s,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic [DEPTH_LOG2-1:0] mem_addr,
    output logic [63:0]           mem_wdata,
    output logic [7:0]            mem_wstrb,
    input  logic [63:0]           mem_rdata
`ifdef AXI4_SRAM_SLAVE_ERRLOG_EN
    ,
    input  logic                  err_clr,
    output logic                  err_vld,
    output logic [31:0]           err_addr
`endif
);
    axi_sram_state_t state, state_n;
    logic [2:0] state_q;
    logic idle, aw_hs, w_hs, ar_hs, acc, in_range, new_err, err_q, first_q, r_hs;
    logic [31:0] acc_addr;
    logic [2:0] acc_size;
    logic [7:0] acc_len, cnt_q, wstrb_q;
    logic [TAG-1:0] id_q;
    logic [DEPTH_LOG2-1:0] addr_q;
    logic [63:0] wdata_q, rbuf_q;
    logic unused_awburst;
    assign unused_awburst = ^s.axi_awburst;
    assign state = axi_sram_state_t'(state_q);
    assign idle = (state == IDLE) & ~rst;
    assign aw_hs = s.axi_awvalid & s.axi_awready;
    assign w_hs = s.axi_wvalid & s.axi_wready;
    assign ar_hs = s.axi_arvalid & s.axi_arready;
    assign r_hs = s.axi_rvalid & s.axi_rready;
    assign acc = aw_hs | ar_hs;
    // AW has priority in IDLE, so the shared checker follows awvalid
    assign acc_addr = s.axi_awvalid ? s.axi_awaddr : s.axi_araddr;
    assign acc_size = s.axi_awvalid ? s.axi_awsize : s.axi_arsize;
    assign acc_len = s.axi_awvalid ? s.axi_awlen : s.axi_arlen;
    rvrangecheck #(.BASE(BASE_ADDR), .SIZE_LOG2(DEPTH_LOG2 + 3)) u_range (
        .addr(acc_addr), .in_range(in_range)
    );
    assign new_err = ~in_range | bad_size(acc_size, acc_addr[2:0]) | (acc_len != 8'd0);
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = aw_hs ? ((w_hs & (s.axi_wlast | ~new_err)) ? WR_MEM : WR_DATA)
                             : ar_hs ? RD_MEM : IDLE;
            WR_DATA: state_n = (w_hs & (s.axi_wlast | ~err_q)) ? WR_MEM : WR_DATA;
            WR_MEM:  state_n = WR_RESP;
            WR_RESP: state_n = s.axi_bready ? IDLE : WR_RESP;
            RD_MEM:  state_n = RD_RESP;
            RD_RESP: state_n = (s.axi_rready & (cnt_q == 8'd0)) ? IDLE : RD_RESP;
            default: state_n = IDLE;
        endcase
    end
    rvdffe #(3) u_state (.clk(clk), .rst(rst), .en(1'b1), .din(state_n), .dout(state_q));
    rvdffe #(TAG) u_id (.clk(clk), .rst(rst), .en(acc), .din(aw_hs ? s.axi_awid : s.axi_arid), .dout(id_q));
    rvdffe #(1) u_err (.clk(clk), .rst(rst), .en(acc), .din(new_err), .dout(err_q));
    rvdffe #(DEPTH_LOG2) u_addr (
        .clk(clk), .rst(rst), .en(acc),
        .din(DEPTH_LOG2'((acc_addr - BASE_ADDR) >> 3)), .dout(addr_q)
    );
    rvdffe #(8) u_cnt (
        .clk(clk), .rst(rst), .en(ar_hs | r_hs),
        .din(ar_hs ? s.axi_arlen : cnt_q - 8'd1), .dout(cnt_q)
    );
    rvdffe #(64) u_wdata (.clk(clk), .rst(rst), .en(w_hs), .din(s.axi_wdata), .dout(wdata_q));
    rvdffe #(8) u_wstrb (.clk(clk), .rst(rst), .en(w_hs), .din(s.axi_wstrb), .dout(wstrb_q));
    // SRAM data arrives on the first RD_RESP cycle; it is passed through then and held in rbuf after
    rvdffe #(1) u_first (.clk(clk), .rst(rst), .en(1'b1), .din(state == RD_MEM), .dout(first_q));
    rvdffe #(64) u_rbuf (.clk(clk), .rst(rst), .en(first_q), .din(mem_rdata), .dout(rbuf_q));
    assign s.axi_awready = idle;
    assign s.axi_arready = idle & ~s.axi_awvalid;
    assign s.axi_wready = (idle & s.axi_awvalid) | (state == WR_DATA);
    assign s.axi_bvalid = state == WR_RESP;
    assign s.axi_bid = id_q;
    assign s.axi_bresp = err_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    assign s.axi_rvalid = state == RD_RESP;
    assign s.axi_rid = id_q;
    assign s.axi_rresp = err_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    assign s.axi_rlast = s.axi_rvalid & (cnt_q == 8'd0);
    assign s.axi_rdata = (s.axi_rvalid & ~err_q) ? (first_q ? mem_rdata : rbuf_q) : 64'd0;
    assign mem_cs = ((state == WR_MEM) | (state == RD_MEM)) & ~err_q;
    assign mem_we = (state == WR_MEM) & ~err_q;
    assign mem_addr = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;
`ifdef AXI4_SRAM_SLAVE_ERRLOG_EN
    logic log_new;
    assign log_new = acc & new_err & ~err_vld;
    rvdffe #(1) u_err_vld (.clk(clk), .rst(rst), .en(1'b1), .din(~err_clr & (err_vld | log_new)), .dout(err_vld));
    rvdffe #(32) u_err_addr (.clk(clk), .rst(rst), .en(~err_clr & log_new), .din(acc_addr), .dout(err_addr));
`endif
endmodule

// File: tb/tb_axi4_sram_slave.sv
// tb_axi4_sram_slave: vector table plus corner sequences, responses checked through a scoreboard queue
module tb_axi4_sram_slave;
    import eh2_pkg::*;
    localparam int TAG = 2;
    localparam int DL = 10;
    localparam logic [31:0] BASE = 32'h0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi4_sram_slave_if #(.TAG(TAG)) bus ();
    logic mem_cs, mem_we;
    logic [DL-1:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata = 64'd0;
    logic [7:0] mem_wstrb;
`ifdef AXI4_SRAM_SLAVE_ERRLOG_EN
    logic err_clr = 1'b0;
    logic err_vld;
    logic [31:0] err_addr;
`endif

    axi4_sram_slave #(.TAG(TAG), .DEPTH_LOG2(DL), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .s(bus),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
`ifdef AXI4_SRAM_SLAVE_ERRLOG_EN
        , .err_clr(err_clr), .err_vld(err_vld), .err_addr(err_addr)
`endif
    );

    logic [63:0] ram [0:(1<<DL)-1];
    int cs_cnt = 0;
    always @(posedge clk) begin
        if (mem_cs) begin
            cs_cnt <= cs_cnt + 1;
            if (mem_we) begin
                for (int i = 0; i < 8; i++)
                    if (mem_wstrb[i]) ram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end else mem_rdata <= ram[mem_addr];
        end
    end

    typedef struct {
        logic [1:0] resp;
        logic [63:0] data;
        logic last;
        logic [TAG-1:0] id;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        bit wr;
        logic [31:0] addr;
        logic [2:0] size;
        logic [7:0] len;
        logic [63:0] data;
        logic [7:0] strb;
        logic [1:0] resp;
        logic [63:0] rdata;
        int cs;
    } vec_t;
    vec_t tv [13];

    int checks = 0;
    int errors = 0;
    int last_wait;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic rdy(input int sel);
        return sel == 0 ? (bus.axi_awready & bus.axi_wready) : sel == 1 ? bus.axi_wready :
               sel == 2 ? bus.axi_arready : sel == 3 ? bus.axi_bvalid : bus.axi_rvalid;
    endfunction

    // Entered just after a rising edge; returns #1 after the edge that completed the handshake
    task automatic xfer(input int sel, input string nm);
        bit ok;
        exp_t e;
        ok = 0;
        last_wait = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rdy(sel)) begin
                ok = 1;
                break;
            end
            last_wait++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s timeout actual=not-ready required=ready", nm);
        end else if (sel >= 3) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s unexpected response actual=1 required=0", nm);
            end else begin
                e = sb.pop_front();
                if (sel == 3) begin
                    chk({nm, " bresp"}, 64'(bus.axi_bresp), 64'(e.resp));
                    chk({nm, " bid"}, 64'(bus.axi_bid), 64'(e.id));
                end else begin
                    chk({nm, " rresp"}, 64'(bus.axi_rresp), 64'(e.resp));
                    chk({nm, " rdata"}, bus.axi_rdata, e.data);
                    chk({nm, " rlast"}, 64'(bus.axi_rlast), 64'(e.last));
                    chk({nm, " rid"}, 64'(bus.axi_rid), 64'(e.id));
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [2:0] sz, input logic [7:0] ln,
                      input logic [63:0] d, input logic [7:0] st, input logic [TAG-1:0] id);
        bus.axi_awvalid = 1'b1; bus.axi_awid = id; bus.axi_awaddr = a;
        bus.axi_awsize = sz; bus.axi_awlen = ln; bus.axi_awburst = 2'b01;
        bus.axi_wvalid = 1'b1; bus.axi_wdata = d; bus.axi_wstrb = st; bus.axi_wlast = (ln == 8'd0);
        xfer(0, "aw");
        bus.axi_awvalid = 1'b0;
        for (int b = 1; b <= int'(ln); b++) begin
            bus.axi_wlast = (b == int'(ln));
            xfer(1, "w");
        end
        bus.axi_wvalid = 1'b0;
        bus.axi_wlast = 1'b0;
        bus.axi_bready = 1'b1;
        xfer(3, "b");
        bus.axi_bready = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [2:0] sz, input logic [7:0] ln,
                      input logic [TAG-1:0] id);
        bus.axi_arvalid = 1'b1; bus.axi_arid = id; bus.axi_araddr = a;
        bus.axi_arsize = sz; bus.axi_arlen = ln;
        xfer(2, "ar");
        bus.axi_arvalid = 1'b0;
        bus.axi_rready = 1'b1;
        for (int b = 0; b <= int'(ln); b++) xfer(4, "r");
        bus.axi_rready = 1'b0;
    endtask

    initial begin
        int c0;
        for (int i = 0; i < (1 << DL); i++) ram[i] = 64'd0;
        bus.axi_awvalid = 0; bus.axi_awid = 0; bus.axi_awaddr = 0; bus.axi_awsize = 0;
        bus.axi_awlen = 0; bus.axi_awburst = 0; bus.axi_wvalid = 0; bus.axi_wdata = 0;
        bus.axi_wstrb = 0; bus.axi_wlast = 0; bus.axi_bready = 0; bus.axi_arvalid = 0;
        bus.axi_arid = 0; bus.axi_araddr = 0; bus.axi_arsize = 0; bus.axi_arlen = 0;
        bus.axi_rready = 0;
        tv = '{
            '{1, 32'h40,   3'd3, 8'd0, 64'h1122334455667788, 8'hFF, AXI_RESP_OKAY,   64'h0, 1},
            '{0, 32'h40,   3'd3, 8'd0, 64'h0, 8'h00, AXI_RESP_OKAY,   64'h1122334455667788, 1},
            '{1, 32'h48,   3'd2, 8'd0, 64'hDEADBEEFCAFEF00D, 8'h0F, AXI_RESP_OKAY, 64'h0, 1},
            '{0, 32'h48,   3'd3, 8'd0, 64'h0, 8'h00, AXI_RESP_OKAY,   64'h00000000CAFEF00D, 1},
            '{1, 32'h42,   3'd2, 8'd0, 64'hFFFF, 8'hFF, AXI_RESP_SLVERR, 64'h0, 0},
            '{1, 32'h2000, 3'd3, 8'd0, 64'hFFFF, 8'hFF, AXI_RESP_SLVERR, 64'h0, 0},
            '{0, 32'h2000, 3'd3, 8'd3, 64'h0, 8'h00, AXI_RESP_SLVERR, 64'h0, 0},
            '{1, 32'h40,   3'd4, 8'd0, 64'hFFFF, 8'hFF, AXI_RESP_SLVERR, 64'h0, 0},
            '{1, 32'h50,   3'd3, 8'd2, 64'hFFFF, 8'hFF, AXI_RESP_SLVERR, 64'h0, 0},
            '{1, 32'h1FF8, 3'd3, 8'd0, 64'h0123456789ABCDEF, 8'hFF, AXI_RESP_OKAY, 64'h0, 1},
            '{0, 32'h1FF8, 3'd3, 8'd0, 64'h0, 8'h00, AXI_RESP_OKAY,   64'h0123456789ABCDEF, 1},
            '{0, 32'h41,   3'd0, 8'd0, 64'h0, 8'h00, AXI_RESP_OKAY,   64'h1122334455667788, 1},
            '{0, 32'h44,   3'd3, 8'd0, 64'h0, 8'h00, AXI_RESP_SLVERR, 64'h0, 0}
        };

        // reset state, with valids presented to prove readies stay low
        bus.axi_awvalid = 1'b1; bus.axi_arvalid = 1'b1;
        #12;
        chk("rst awready", 64'(bus.axi_awready), 0);
        chk("rst arready", 64'(bus.axi_arready), 0);
        chk("rst wready", 64'(bus.axi_wready), 0);
        chk("rst bvalid", 64'(bus.axi_bvalid), 0);
        chk("rst rvalid", 64'(bus.axi_rvalid), 0);
        chk("rst mem_cs", 64'(mem_cs), 0);
        chk("rst rdata", bus.axi_rdata, 0);
        chk("rst bresp", 64'(bus.axi_bresp), 0);
        bus.axi_awvalid = 1'b0; bus.axi_arvalid = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;

        // write timing: accept at N, SRAM write at N+1, B at N+2
        bus.axi_awvalid = 1'b1; bus.axi_awid = 2'd2; bus.axi_awaddr = 32'h40; bus.axi_awsize = 3'd3;
        bus.axi_awlen = 8'd0; bus.axi_wvalid = 1'b1; bus.axi_wdata = 64'h1122334455667788;
        bus.axi_wstrb = 8'hFF; bus.axi_wlast = 1'b1;
        @(negedge clk);
        chk("A awready", 64'(bus.axi_awready), 1);
        chk("A wready", 64'(bus.axi_wready), 1);
        @(posedge clk); #1;
        bus.axi_awvalid = 1'b0; bus.axi_wvalid = 1'b0;
        @(negedge clk);
        chk("A mem_we", 64'(mem_we), 1);
        chk("A mem_cs", 64'(mem_cs), 1);
        chk("A mem_addr", 64'(mem_addr), 8);
        chk("A mem_wdata", mem_wdata, 64'h1122334455667788);
        chk("A mem_wstrb", 64'(mem_wstrb), 8'hFF);
        chk("A bvalid N+1", 64'(bus.axi_bvalid), 0);
        @(negedge clk);
        chk("A bvalid N+2", 64'(bus.axi_bvalid), 1);
        chk("A bresp", 64'(bus.axi_bresp), 0);
        chk("A bid", 64'(bus.axi_bid), 2);
        chk("A mem_cs N+2", 64'(mem_cs), 0);
        @(posedge clk); #1; bus.axi_bready = 1'b1;
        @(posedge clk); #1; bus.axi_bready = 1'b0;

        // read timing with rready stalled
        sb.push_back('{AXI_RESP_OKAY, 64'h0, 1'b0, 2'd0});
        wr(32'h40, 3'd3, 8'd0, 64'hA5A5, 8'hFF, 2'd0);
        bus.axi_arvalid = 1'b1; bus.axi_arid = 2'd1; bus.axi_araddr = 32'h40;
        bus.axi_arsize = 3'd3; bus.axi_arlen = 8'd0;
        @(negedge clk);
        chk("B arready", 64'(bus.axi_arready), 1);
        @(posedge clk); #1; bus.axi_arvalid = 1'b0;
        @(negedge clk);
        chk("B mem_cs", 64'(mem_cs), 1);
        chk("B mem_we", 64'(mem_we), 0);
        chk("B mem_addr", 64'(mem_addr), 8);
        chk("B rvalid N+1", 64'(bus.axi_rvalid), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("B rvalid", 64'(bus.axi_rvalid), 1);
            chk("B rdata", bus.axi_rdata, 64'hA5A5);
            chk("B rlast", 64'(bus.axi_rlast), 1);
            chk("B rresp", 64'(bus.axi_rresp), 0);
            chk("B rid", 64'(bus.axi_rid), 1);
        end
        @(posedge clk); #1; bus.axi_rready = 1'b1;
        @(posedge clk); #1; bus.axi_rready = 1'b0;
        @(negedge clk);
        chk("B rvalid after", 64'(bus.axi_rvalid), 0);
        chk("B arready after", 64'(bus.axi_arready), 1);
`ifdef AXI4_SRAM_SLAVE_ERRLOG_EN
        chk("err_vld clean", 64'(err_vld), 0);
`endif
        @(posedge clk); #1;

        foreach (tv[k]) begin
            c0 = cs_cnt;
            if (tv[k].wr) begin
                sb.push_back('{tv[k].resp, 64'h0, 1'b0, TAG'(k)});
                wr(tv[k].addr, tv[k].size, tv[k].len, tv[k].data, tv[k].strb, TAG'(k));
            end else begin
                for (int b = 0; b <= int'(tv[k].len); b++)
                    sb.push_back('{tv[k].resp, tv[k].rdata, b == int'(tv[k].len), TAG'(k)});
                rd(tv[k].addr, tv[k].size, tv[k].len, TAG'(k));
            end
            chk($sformatf("v%0d mem_cs count", k), 64'(cs_cnt - c0), 64'(tv[k].cs));
            chk($sformatf("v%0d sb drained", k), 64'(sb.size()), 0);
        end

`ifdef AXI4_SRAM_SLAVE_ERRLOG_EN
        chk("err_vld", 64'(err_vld), 1);
        chk("err_addr", 64'(err_addr), 32'h42);
        err_clr = 1'b1;
        @(posedge clk); #1; err_clr = 1'b0;
        chk("err_vld cleared", 64'(err_vld), 0);
`endif

        // AW and AR together: write first, AR taken on the first IDLE after B
        sb.push_back('{AXI_RESP_OKAY, 64'h0, 1'b0, 2'd1});
        sb.push_back('{AXI_RESP_OKAY, 64'h55AA55AA12345678, 1'b1, 2'd2});
        bus.axi_awvalid = 1'b1; bus.axi_awid = 2'd1; bus.axi_awaddr = 32'h60; bus.axi_awsize = 3'd3;
        bus.axi_awlen = 8'd0; bus.axi_wvalid = 1'b1; bus.axi_wdata = 64'h55AA55AA12345678;
        bus.axi_wstrb = 8'hFF; bus.axi_wlast = 1'b1;
        bus.axi_arvalid = 1'b1; bus.axi_arid = 2'd2; bus.axi_araddr = 32'h60;
        bus.axi_arsize = 3'd3; bus.axi_arlen = 8'd0;
        bus.axi_bready = 1'b1; bus.axi_rready = 1'b1;
        @(negedge clk);
        chk("C awready", 64'(bus.axi_awready), 1);
        chk("C arready blocked", 64'(bus.axi_arready), 0);
        @(posedge clk); #1;
        bus.axi_awvalid = 1'b0; bus.axi_wvalid = 1'b0;
        xfer(3, "C b");
        xfer(2, "C ar");
        chk("C ar bubble", 64'(last_wait), 0);
        bus.axi_arvalid = 1'b0;
        xfer(4, "C r");
        bus.axi_bready = 1'b0; bus.axi_rready = 1'b0;

        // reset while the read response is pending drops it
        bus.axi_arvalid = 1'b1; bus.axi_arid = 2'd3; bus.axi_araddr = 32'h40;
        bus.axi_arsize = 3'd3; bus.axi_arlen = 8'd0;
        xfer(2, "D ar");
        bus.axi_arvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("D rvalid before rst", 64'(bus.axi_rvalid), 1);
        #2 rst = 1'b1;
        #1;
        chk("D rvalid in rst", 64'(bus.axi_rvalid), 0);
        chk("D arready in rst", 64'(bus.axi_arready), 0);
        chk("D rdata in rst", bus.axi_rdata, 0);
        chk("D rid in rst", 64'(bus.axi_rid), 0);
        chk("D mem_cs in rst", 64'(mem_cs), 0);
        @(posedge clk); #1; rst = 1'b0;
        sb.push_back('{AXI_RESP_OKAY, 64'h1122334455667788, 1'b1, 2'd1});
        rd(32'h40, 3'd3, 8'd0, 2'd1);
        chk("D sb drained", 64'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi4_sram_slave.md
AXI4_SRAM_SLAVE -- requirements
Module: axi4_sram_slave

Interface
REQ-001 SHALL have parameter TAG, default 1, AXI ID width.
REQ-002 SHALL have parameter DEPTH_LOG2, default 10, log2 of the number of 64-bit SRAM words.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0, byte base address; it is aligned to 8*2^DEPTH_LOG2.
REQ-004 SHALL have ports: clk in 1, clock; rst in 1, reset, asynchronous, active-high.
REQ-005 SHALL have AW ports: axi_awvalid in 1; axi_awready out 1; axi_awid in TAG; axi_awaddr in 32; axi_awsize in 3; axi_awlen in 8; axi_awburst in 2.
REQ-006 SHALL have W ports: axi_wvalid in 1; axi_wready out 1; axi_wdata in 64; axi_wstrb in 8; axi_wlast in 1.
REQ-007 SHALL have B ports: axi_bvalid out 1; axi_bready in 1; axi_bid out TAG; axi_bresp out 2.
REQ-008 SHALL have AR ports: axi_arvalid in 1; axi_arready out 1; axi_arid in TAG; axi_araddr in 32; axi_arsize in 3; axi_arlen in 8.
REQ-009 SHALL have R ports: axi_rvalid out 1; axi_rready in 1; axi_rid out TAG; axi_rdata out 64; axi_rresp out 2; axi_rlast out 1.
REQ-010 SHALL have SRAM ports: mem_cs out 1; mem_we out 1; mem_addr out DEPTH_LOG2 (word index); mem_wdata out 64; mem_wstrb out 8; mem_rdata in 64, valid one cycle after a read mem_cs.

Function
REQ-011 SHALL use states IDLE, WR_DATA, WR_MEM, WR_RESP, RD_MEM, RD_RESP.
REQ-012 SHALL assert axi_awready and axi_arready only in IDLE; if both AW and AR are valid in IDLE, AW wins and AR waits.
REQ-013 SHALL assert axi_wready in IDLE only when axi_awvalid is high, and always in WR_DATA; a W beat presented before AW is not accepted.
REQ-014 SHALL flag a transaction as error (resp 2'b10, SLVERR) when any of these hold: the address is outside [BASE_ADDR, BASE_ADDR+8*2^DEPTH_LOG2); the address is unaligned to the size; size > 3; len != 0. Otherwise resp is 2'b00.
REQ-015 SHALL handle writes as follows: AW and W accepted in cycle N go to WR_MEM; if there is no error, mem_cs=mem_we=1 in N+1 with the captured wstrb and data; axi_bvalid is asserted from N+2 and held until axi_bready; axi_bid returns awid.
REQ-016 SHALL, on an error write, consume W beats until axi_wlast, issue no mem_cs, and then respond SLVERR.
REQ-017 SHALL handle reads as follows: AR accepted in cycle N moves to RD_MEM, with mem_cs=1 and mem_we=0 in N+1; axi_rvalid is asserted from N+2; axi_rdata is held stable from an internal buffer until axi_rready; axi_rlast=1.
REQ-018 SHALL, on an error read, issue no mem_cs and return arlen+1 beats with rdata=0 and SLVERR, using an 8-bit beat counter; rlast is asserted on the final beat only.
REQ-019 SHALL return to IDLE on the last B or R handshake; a new AW/AR is accepted in the following cycle, giving 0 bubbles beyond the IDLE cycle.
REQ-020 SHALL compute mem_addr as (addr - BASE_ADDR)[DEPTH_LOG2+2:3]; no wrap-around is allowed, because out-of-range addresses are errors.
REQ-021 SHALL require axi_bid/axi_rid to equal the accepted id; axi_awburst is ignored.

Reset
REQ-022 SHALL, on rst=1, enter IDLE immediately, asynchronously.
REQ-023 SHALL, while in reset, hold all ready/valid outputs, mem_cs and mem_we at 0, and hold data, id and resp outputs at 0.
REQ-024 SHALL drop any transaction in flight on reset mid-operation; no B or R response is returned for it.

Configuration
REQ-025 SHALL support macro AXI4_SRAM_SLAVE_ERRLOG_EN.
REQ-026 SHALL, when the macro is defined, add ports err_clr in 1, err_vld out 1 and err_addr out 32; the first SLVERR address is captured and held sticky until err_clr, and err_clr takes priority over a simultaneous new error.
REQ-027 SHALL, when the macro is undefined, omit these ports and logic.

Structure
REQ-028 SHALL place typedef axi_sram_state_t and the constants AXI_RESP_OKAY=2'b00 and AXI_RESP_SLVERR=2'b10 in eh2_pkg.
REQ-029 SHALL use rvrangecheck for the address range test, instanced once, with its input muxed from the AW or AR address.
REQ-030 SHALL use rvdff-family flops for all state.

Verification
REQ-031 SHALL cover: AW+W at 0x40, size 3, wstrb 8'hFF, data 64'h1122334455667788 -> mem_we in N+1 at mem_addr 8; bresp 00 at N+2.
REQ-032 SHALL cover: AR at 0x40 with mem_rdata=64'hA5A5 -> rvalid at N+2 with rdata 64'hA5A5, rresp 00, rlast 1; rready held low 3 cycles leaves rdata stable.
REQ-033 SHALL cover: AR at BASE+8*2^DEPTH_LOG2 with arlen=3 -> 4 beats of SLVERR, rlast on the 4th, no mem_cs.
REQ-034 SHALL cover: AW at 0x42, size 2 (unaligned) -> SLVERR, no mem_we; with ERRLOG_EN, err_vld=1 and err_addr=0x42.
REQ-035 SHALL cover: AW and AR valid in the same IDLE cycle -> write completes first, then AR accepted on the next IDLE.
REQ-036 SHALL cover: rst asserted during RD_RESP -> rvalid=0 immediately, state IDLE, next AR served normally.
